// File: rtl/instr_fetch_pkg.sv
// Shared widths, reset PC, fetch FSM encoding and the {pc, instr} entry type
// used by the instruction fetch unit.
package instr_fetch_pkg;

   localparam int ADDRESS_BUS_WIDTH  = 24;
   localparam int INSTRUCTION_WIDTH  = 33;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   localparam logic [ADDRESS_BUS_WIDTH-1:0] RESET_PC = 24'd1024;

   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [ADDRESS_BUS_WIDTH-1:0] pc;
      logic [INSTRUCTION_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// IRAM read port plus the decode-side valid/ready channel of the fetch unit.
// The master modport is the fetch side; slave is the IRAM/decode side.
interface instr_fetch_if;
   import instr_fetch_pkg::*;

   logic [ADDRESS_BUS_WIDTH-1:0] iram_address;
   logic                         iram_read_not_write;
   logic [INSTRUCTION_WIDTH-1:0] iram_data;

   logic                         instr_valid;
   logic                         instr_ready;
   logic [INSTRUCTION_WIDTH-1:0] instr_data;
   logic [ADDRESS_BUS_WIDTH-1:0] instr_pc;

   modport master (
      output iram_address, iram_read_not_write,
      input  iram_data,
      output instr_valid, instr_data, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  iram_address, iram_read_not_write,
      output iram_data,
      input  instr_valid, instr_data, instr_pc,
      output instr_ready
   );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous {pc, instr} FIFO with flush. When empty, the head outputs
// keep showing the last entry that was presented.
module fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           push_entry,
   input  logic                   pop,
   output logic [$clog2(DEPTH):0] count,
   output logic                   head_valid,
   output fetch_entry_t           head_entry
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   fetch_entry_t             last_q, last_d;
   logic                     do_pop;

   always_comb begin
      head_valid = (count_q != '0);
      head_entry = head_valid ? mem_q[rd_ptr_q] : last_q;
      do_pop     = pop && head_valid;
      last_d     = head_entry;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: entries are only observable once counted.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         last_q   <= last_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues sequential IRAM reads under a FIFO credit limit,
// tracks the 1-cycle read latency and flushes everything on a redirect.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fetch_enable,
   input  logic                         redirect_valid,
   input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_pc,
   instr_fetch_if.master                bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 1;

   fetch_state_e                 state_q, state_d;
   logic [ADDRESS_BUS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDRESS_BUS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                         inflight_q, inflight_d;

   logic [CW-1:0]                fifo_count;
   logic [SW-1:0]                credit_used;
   logic                         issue;
   logic                         push;
   logic                         pop;
   logic                         head_valid;
   fetch_entry_t                 push_entry;
   fetch_entry_t                 head_entry;

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_IDLE: if (fetch_enable)  state_d = FETCH_RUN;
         FETCH_RUN:  if (!fetch_enable) state_d = FETCH_IDLE;
         default:                       state_d = FETCH_IDLE;
      endcase
   end

   // Credits count the in-flight read too, so a returning word always has a slot.
   always_comb begin
      credit_used   = SW'(fifo_count) + SW'(inflight_q);
      issue         = (state_q == FETCH_RUN) && fetch_enable && !redirect_valid &&
                      (credit_used < SW'(FIFO_DEPTH));
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = issue;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + ADDRESS_BUS_WIDTH'(1);
         inflight_pc_d = fetch_pc_q;
      end
      push       = inflight_q && !redirect_valid;
      push_entry = '{pc: inflight_pc_q, instr: bus.iram_data};
      pop        = head_valid && bus.instr_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= FETCH_IDLE;
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .count      (fifo_count),
      .head_valid (head_valid),
      .head_entry (head_entry)
   );

   assign bus.iram_address        = fetch_pc_q;
   assign bus.iram_read_not_write = 1'b1;
   assign bus.instr_valid         = head_valid;
   assign bus.instr_data          = head_entry.instr;
   assign bus.instr_pc            = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, with a
// scoreboard holding the expected accepted {pc, instr} stream.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam int AW      = ADDRESS_BUS_WIDTH;
   localparam int IW      = INSTRUCTION_WIDTH;
   localparam int DEPTH   = 4;
   localparam int SB_FILL = 256;

   typedef struct {
      logic [AW-1:0] pc;
      logic [IW-1:0] data;
   } exp_t;

   logic          clk            = 1'b0;
   logic          rst            = 1'b1;
   logic          fetch_enable   = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc    = '0;

   int            checks   = 0;
   int            errors   = 0;
   int            hs_count = 0;
   exp_t          sb[$];
   exp_t          mon_e;
   logic [IW-1:0] iram [int];

   instr_fetch_if bus ();

   instr_fetch #(.FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_enable   (fetch_enable),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] ram_word(input logic [AW-1:0] a);
      if (iram.exists(int'(a))) return iram[int'(a)];
      return {a ^ 24'h5a5a5a, 9'h1c3};
   endfunction

   // Expected decode stream after a (re)start: consecutive words from start.
   function automatic void refill(input logic [AW-1:0] start);
      logic [AW-1:0] p;
      p = start;
      sb.delete();
      for (int i = 0; i < SB_FILL; i++) begin
         sb.push_back('{pc: p, data: ram_word(p)});
         p = p + 1'b1;
      end
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // IRAM with registered read.
   always @(posedge clk) bus.iram_data <= ram_word(bus.iram_address);

   // Monitor: handshakes of a cycle count before that cycle's restart.
   always @(negedge clk) begin
      chk("read_not_write", 64'(bus.iram_read_not_write), 64'd1);
      if (!rst && bus.instr_valid && bus.instr_ready) begin
         hs_count++;
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("sb_pc", 64'(bus.instr_pc), 64'(mon_e.pc));
            chk("sb_data", 64'(bus.instr_data), 64'(mon_e.data));
         end
      end
      if (rst) refill(RESET_PC);
      else if (redirect_valid) refill(redirect_pc);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, output int n);
      n = 0;
      while (!bus.instr_valid && n < 30) begin
         tick(1);
         n++;
      end
      if (!bus.instr_valid) chk(name, 64'(bus.instr_valid), 64'd1);
   endtask

   task automatic do_reset(input logic rdy);
      rst            = 1'b1;
      fetch_enable   = 1'b0;
      redirect_valid = 1'b0;
      bus.instr_ready = rdy;
      tick(2);
      rst          = 1'b0;
      fetch_enable = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hs_before;
      iram[1024]     = 33'h021000000;
      iram[1025]     = 33'h022000000;
      iram[1026]     = 33'h02300000B;
      iram[1027]     = 33'h052210000;
      iram[24'hFFFFFF] = 33'h1DEADBEEF;
      iram[0]        = 33'h0CAFEF00D;
      bus.instr_ready = 1'b1;

      // Reset state
      tick(3);
      chk("rst_valid", 64'(bus.instr_valid), 64'd0);
      chk("rst_data", 64'(bus.instr_data), 64'd0);
      chk("rst_pc", 64'(bus.instr_pc), 64'd0);
      chk("rst_addr", 64'(bus.iram_address), 64'd1024);

      // Start-up latency and first three words
      rst = 1'b0;
      fetch_enable = 1'b1;
      wait_valid("first_valid_timeout", n);
      chk("first_valid_latency", 64'(n), 64'd3);
      chk("t1_pc0", 64'(bus.instr_pc), 64'd1024);
      chk("t1_data0", 64'(bus.instr_data), 64'h021000000);
      tick(1);
      chk("t1_valid1", 64'(bus.instr_valid), 64'd1);
      chk("t1_pc1", 64'(bus.instr_pc), 64'd1025);
      chk("t1_data1", 64'(bus.instr_data), 64'h022000000);
      tick(1);
      chk("t1_valid2", 64'(bus.instr_valid), 64'd1);
      chk("t1_pc2", 64'(bus.instr_pc), 64'd1026);
      chk("t1_data2", 64'(bus.instr_data), 64'h02300000B);

      // Back-pressure: exactly DEPTH issues, then drain in order
      do_reset(1'b0);
      tick(10);
      chk("stall_fetch_pc", 64'(bus.iram_address), 64'd1028);
      chk("stall_valid", 64'(bus.instr_valid), 64'd1);
      chk("stall_head", 64'(bus.instr_pc), 64'd1024);
      tick(3);
      chk("stall_hold_pc", 64'(bus.iram_address), 64'd1028);
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 64'(bus.instr_valid), 64'd1);
         chk("drain_pc", 64'(bus.instr_pc), 64'(1024 + k));
         tick(1);
      end

      // Redirect with 3 buffered and 1 in flight
      do_reset(1'b0);
      tick(5);
      chk("pre_redir_addr", 64'(bus.iram_address), 64'd1028);
      redirect_valid = 1'b1;
      redirect_pc    = 24'd1027;
      tick(1);
      redirect_valid = 1'b0;
      chk("redir_valid_t1", 64'(bus.instr_valid), 64'd0);
      tick(1);
      chk("redir_valid_t2", 64'(bus.instr_valid), 64'd0);
      tick(1);
      chk("redir_valid_t3", 64'(bus.instr_valid), 64'd1);
      chk("redir_pc", 64'(bus.instr_pc), 64'd1027);
      chk("redir_data", 64'(bus.instr_data), 64'h052210000);
      bus.instr_ready = 1'b1;
      tick(4);

      // Redirect coincident with a handshake on 1025
      do_reset(1'b1);
      tick(4);
      chk("hs_redir_head", 64'(bus.instr_pc), 64'd1025);
      redirect_valid = 1'b1;
      redirect_pc    = 24'd2000;
      tick(1);
      redirect_valid = 1'b0;
      wait_valid("hs_redir_timeout", n);
      chk("hs_redir_pc", 64'(bus.instr_pc), 64'd2000);

      // Back-to-back redirects: only the last target is fetched
      redirect_valid = 1'b1;
      redirect_pc    = 24'd3000;
      tick(1);
      redirect_pc = 24'd3100;
      tick(1);
      redirect_pc = 24'd3200;
      tick(1);
      redirect_valid = 1'b0;
      wait_valid("b2b_timeout", n);
      chk("b2b_pc", 64'(bus.instr_pc), 64'd3200);

      // PC wrap
      redirect_valid = 1'b1;
      redirect_pc    = 24'hFFFFFF;
      tick(1);
      redirect_valid = 1'b0;
      wait_valid("wrap_timeout", n);
      chk("wrap_pc_top", 64'(bus.instr_pc), 64'hFFFFFF);
      tick(1);
      chk("wrap_valid", 64'(bus.instr_valid), 64'd1);
      chk("wrap_pc_zero", 64'(bus.instr_pc), 64'd0);

      // Reset mid-stream with 3 buffered
      do_reset(1'b0);
      tick(5);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_valid", 64'(bus.instr_valid), 64'd0);
      chk("mid_rst_pc", 64'(bus.instr_pc), 64'd0);
      chk("mid_rst_data", 64'(bus.instr_data), 64'd0);
      chk("mid_rst_addr", 64'(bus.iram_address), 64'd1024);
      rst = 1'b0;
      bus.instr_ready = 1'b1;
      wait_valid("mid_rst_timeout", n);
      chk("mid_rst_latency", 64'(n), 64'd3);
      chk("mid_rst_restart_pc", 64'(bus.instr_pc), 64'd1024);

      // Random traffic
      for (int cyc = 0; cyc < 1500; cyc++) begin
         bus.instr_ready = ($urandom_range(3) != 0);
         fetch_enable    = ($urandom_range(7) != 0);
         redirect_valid  = ($urandom_range(19) == 0);
         redirect_pc     = ($urandom_range(3) == 0) ? AW'(32'hFFFFFF - $urandom_range(3))
                                                    : AW'($urandom_range(4095));
         tick(1);
      end
      redirect_valid  = 1'b0;
      fetch_enable    = 1'b1;
      bus.instr_ready = 1'b1;
      tick(5);
      hs_before = hs_count;
      tick(20);
      chk("steady_throughput", 64'(hs_count - hs_before), 64'd20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
